hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
- Pipeline hazard controller for the 5-stage MIPS core.
- Produces the decode-stage forward selects (forward_a_D, forward_b_D) and execute-stage forward selects, plus stall_F/stall_D/flush_E.
- Sequences the multi-cycle multiply/divide unit with a busy countdown, stalling HI/LO readers and back-to-back mult/div until the result is ready.
- Sits beside the datapath; consumes register specifiers and control bits from D/E/M/W, drives mux selects and pipeline-register enables.

Parameters:
- MULT_CYCLES, 4, cycles from mult issue in E until HI/LO valid (≥1)
- DIV_CYCLES, 32, cycles from div issue in E until HI/LO valid (≥1)
- CNT_W, 6, busy-counter width; must hold max(MULT_CYCLES, DIV_CYCLES)

Ports:
- clk  in  1  core clock
- reset  in  1  synchronous, active-high reset
- rs_D, rt_D  in  5  source registers in decode
- rs_E, rt_E  in  5  source registers in execute
- write_reg_E, write_reg_M, write_reg_W  in  5  destination register per stage
- reg_write_E, reg_write_M, reg_write_W  in  1  stage writes register file
- mem_to_reg_E, mem_to_reg_M  in  1  stage holds a load
- branch_D  in  1  branch or jr in decode; comparison/target uses src_a_D/src_b_D
- md_op_D  in  1  mult/div/mthi/mtlo in decode
- mfhilo_D  in  1  mfhi/mflo in decode
- md_start_E  in  1  mult/div issuing in execute this cycle
- md_is_div_E  in  1  qualifies md_start_E: 1 = div, 0 = mult
- forward_a_D, forward_b_D  out  1  select alu_out_M in decode
- forward_a_E, forward_b_E  out  2  00 = RF/ID value, 10 = alu_out_M, 01 = result_W
- stall_F, stall_D  out  1  hold PC / IF-ID register
- flush_E  out  1  clear ID-EX register (bubble)
- md_busy  out  1  mult/div in progress

Behaviour:
- One clock: clk. Reset is synchronous and active-high: `reset`.
- Register 0 never matches; every compare requires its specifier != 0.
- forward_a_D = reg_write_M & (write_reg_M == rs_D) & !mem_to_reg_M; forward_b_D is the same with rt_D.
- forward_a_E = 10 if reg_write_M & write_reg_M == rs_E; else 01 if reg_write_W & write_reg_W == rs_E; else 00. M has priority. forward_b_E is the same with rt_E.
- lw_stall = mem_to_reg_E & (write_reg_E == rs_D or write_reg_E == rt_D).
- br_stall = branch_D & ((reg_write_E & write_reg_E ∈ {rs_D, rt_D}) | (mem_to_reg_M & write_reg_M ∈ {rs_D, rt_D})).
- Mult/div counter (state IDLE/BUSY, down-counter cnt):
  - In IDLE, md_start_E loads cnt = (md_is_div_E ? DIV_CYCLES : MULT_CYCLES) and moves to BUSY.
  - In BUSY, cnt decrements each cycle; it returns to IDLE in the cycle cnt reaches 1, so BUSY lasts exactly N cycles.
  - md_busy = (state == BUSY).
  - md_start_E while BUSY cannot occur, because md_stall prevents it. If it does occur, it is ignored and the counter is not reloaded (assertion in bench).
- md_stall = (mfhilo_D | md_op_D) & (md_busy | md_start_E).
- stall_F = stall_D = flush_E = lw_stall | br_stall | md_stall.
- Combinational outputs depend on current inputs and state only; there is no added latency.
- Reset: state = IDLE, cnt = 0, md_busy = 0. While reset is high, all stall/flush/forward outputs are forced to 0.
- Reset asserted mid-BUSY aborts the operation; md_busy = 0 on the cycle after the reset edge.
- Simultaneous lw_stall and md_stall produce a single stall (OR); no counter side effects.

Decomposition:
- Shared package (hazard_pkg):
  - localparams FWD_RF = 2'b00, FWD_W = 2'b01, FWD_M = 2'b10
  - state encoding MD_IDLE, MD_BUSY
- One natural sub-module: md_busy_cnt, holding the counter and FSM. Its interface is clk, reset, start, is_div → busy, last.
- Forwarding and stall equations stay in the top level.

Test Plan:
- lw $2 in E, add $3,$2,$4 in D (mem_to_reg_E = 1, write_reg_E = 2, rs_D = 2) → stall_F = stall_D = flush_E = 1 for exactly 1 cycle; next cycle forward_a_E = 01.
- beq $5,$6 in D, with add $5 in M (reg_write_M = 1, write_reg_M = 5, mem_to_reg_M = 0) → forward_a_D = 1, no stall. Same case with add $5 in E → 1-cycle stall, then forward_a_D = 1.
- write_reg_M = 0, reg_write_M = 1, rs_D = 0 → forward_a_D = 0 and forward_a_E = 00.
- Both M and W write $7, rs_E = 7 → forward_a_E = 10 (M priority).
- div issue (md_start_E = 1, md_is_div_E = 1), then mfhi in D the next cycle → md_busy = 1 for 32 cycles; stall held 32 cycles; mfhi leaves D on the first cycle md_busy = 0. Repeat with mult → 4 cycles.
- reset pulsed 1 cycle at cycle 10 of a div → md_busy = 0 and stalls = 0 from the next cycle; a subsequent mult gives a 4-cycle busy.

Source files
------------

// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared encodings and helpers for the pipeline hazard controller
package hazard_pkg;

   localparam logic [1:0] FWD_RF = 2'b00;
   localparam logic [1:0] FWD_W  = 2'b01;
   localparam logic [1:0] FWD_M  = 2'b10;

   typedef enum logic {
      MD_IDLE,
      MD_BUSY
   } md_state_t;

   // $0 is hard-wired, so a zero specifier can never create a dependency
   function automatic logic reg_match(input logic [4:0] src, input logic [4:0] dst);
      return (src != 5'd0) && (src == dst);
   endfunction

endpackage

// File: rtl/md_busy_cnt.sv
// rtl/md_busy_cnt.sv - multi-cycle mult/div busy countdown
module md_busy_cnt
   import hazard_pkg::*;
#(
   parameter int MULT_CYCLES = 4,
   parameter int DIV_CYCLES  = 32,
   parameter int CNT_W       = 6
) (
   input  logic clk,
   input  logic reset,
   input  logic start,
   input  logic is_div,
   output logic busy,
   output logic last
);

   localparam logic [CNT_W-1:0] MULT_N  = CNT_W'(MULT_CYCLES);
   localparam logic [CNT_W-1:0] DIV_N   = CNT_W'(DIV_CYCLES);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   md_state_t        state, state_nx;
   logic [CNT_W-1:0] cnt, cnt_nx;

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= MD_IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
      end
   end

   // A start while busy is ignored; the running operation keeps its count
   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      case (state)
         MD_IDLE: begin
            if (start) begin
               state_nx = MD_BUSY;
               cnt_nx   = is_div ? DIV_N : MULT_N;
            end
         end
         MD_BUSY: begin
            if (cnt <= CNT_ONE) begin
               state_nx = MD_IDLE;
               cnt_nx   = '0;
            end else begin
               cnt_nx = cnt - CNT_ONE;
            end
         end
         default: begin
            state_nx = MD_IDLE;
            cnt_nx   = '0;
         end
      endcase
   end

   assign busy = (state == MD_BUSY);
   assign last = busy && (cnt == CNT_ONE);

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - forwarding selects, stalls and flushes for the 5-stage core
module hazard_ctrl
   import hazard_pkg::*;
#(
   parameter int MULT_CYCLES = 4,
   parameter int DIV_CYCLES  = 32,
   parameter int CNT_W       = 6
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [4:0] rs_D,
   input  logic [4:0] rt_D,
   input  logic [4:0] rs_E,
   input  logic [4:0] rt_E,
   input  logic [4:0] write_reg_E,
   input  logic [4:0] write_reg_M,
   input  logic [4:0] write_reg_W,
   input  logic       reg_write_E,
   input  logic       reg_write_M,
   input  logic       reg_write_W,
   input  logic       mem_to_reg_E,
   input  logic       mem_to_reg_M,
   input  logic       branch_D,
   input  logic       md_op_D,
   input  logic       mfhilo_D,
   input  logic       md_start_E,
   input  logic       md_is_div_E,
   output logic       forward_a_D,
   output logic       forward_b_D,
   output logic [1:0] forward_a_E,
   output logic [1:0] forward_b_E,
   output logic       stall_F,
   output logic       stall_D,
   output logic       flush_E,
   output logic       md_busy
);

   logic lw_stall, br_stall, md_stall, any_stall;
   logic md_last_unused;

   // last is for the datapath's HI/LO capture; hazard logic only needs busy
   md_busy_cnt #(
      .MULT_CYCLES(MULT_CYCLES),
      .DIV_CYCLES (DIV_CYCLES),
      .CNT_W      (CNT_W)
   ) u_md_busy_cnt (
      .clk   (clk),
      .reset (reset),
      .start (md_start_E),
      .is_div(md_is_div_E),
      .busy  (md_busy),
      .last  (md_last_unused)
   );

   assign lw_stall = mem_to_reg_E &
                     (reg_match(rs_D, write_reg_E) | reg_match(rt_D, write_reg_E));

   // Branch operands are compared in D, so a producer still in E, or a load in M, must wait
   assign br_stall = branch_D &
                     ((reg_write_E  & (reg_match(rs_D, write_reg_E) | reg_match(rt_D, write_reg_E))) |
                      (mem_to_reg_M & (reg_match(rs_D, write_reg_M) | reg_match(rt_D, write_reg_M))));

   assign md_stall  = (mfhilo_D | md_op_D) & (md_busy | md_start_E);
   assign any_stall = lw_stall | br_stall | md_stall;

   always_comb begin
      forward_a_D = 1'b0;
      forward_b_D = 1'b0;
      forward_a_E = FWD_RF;
      forward_b_E = FWD_RF;
      stall_F     = 1'b0;
      stall_D     = 1'b0;
      flush_E     = 1'b0;
      if (!reset) begin
         forward_a_D = reg_write_M & reg_match(rs_D, write_reg_M) & !mem_to_reg_M;
         forward_b_D = reg_write_M & reg_match(rt_D, write_reg_M) & !mem_to_reg_M;

         if (reg_write_M && reg_match(rs_E, write_reg_M))      forward_a_E = FWD_M;
         else if (reg_write_W && reg_match(rs_E, write_reg_W)) forward_a_E = FWD_W;

         if (reg_write_M && reg_match(rt_E, write_reg_M))      forward_b_E = FWD_M;
         else if (reg_write_W && reg_match(rt_E, write_reg_W)) forward_b_E = FWD_W;

         stall_F = any_stall;
         stall_D = any_stall;
         flush_E = any_stall;
      end
   end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - scoreboard bench for hazard_ctrl
module tb_hazard_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic [4:0] rs_D, rt_D, rs_E, rt_E;
   logic [4:0] write_reg_E, write_reg_M, write_reg_W;
   logic       reg_write_E, reg_write_M, reg_write_W;
   logic       mem_to_reg_E, mem_to_reg_M;
   logic       branch_D, md_op_D, mfhilo_D, md_start_E, md_is_div_E;
   logic       forward_a_D, forward_b_D;
   logic [1:0] forward_a_E, forward_b_E;
   logic       stall_F, stall_D, flush_E, md_busy;

   always #5 clk = ~clk;

   hazard_ctrl dut (
      .clk         (clk),
      .reset       (reset),
      .rs_D        (rs_D),
      .rt_D        (rt_D),
      .rs_E        (rs_E),
      .rt_E        (rt_E),
      .write_reg_E (write_reg_E),
      .write_reg_M (write_reg_M),
      .write_reg_W (write_reg_W),
      .reg_write_E (reg_write_E),
      .reg_write_M (reg_write_M),
      .reg_write_W (reg_write_W),
      .mem_to_reg_E(mem_to_reg_E),
      .mem_to_reg_M(mem_to_reg_M),
      .branch_D    (branch_D),
      .md_op_D     (md_op_D),
      .mfhilo_D    (mfhilo_D),
      .md_start_E  (md_start_E),
      .md_is_div_E (md_is_div_E),
      .forward_a_D (forward_a_D),
      .forward_b_D (forward_b_D),
      .forward_a_E (forward_a_E),
      .forward_b_E (forward_b_E),
      .stall_F     (stall_F),
      .stall_D     (stall_D),
      .flush_E     (flush_E),
      .md_busy     (md_busy)
   );

   typedef struct packed {
      logic       fa_d;
      logic       fb_d;
      logic [1:0] fa_e;
      logic [1:0] fb_e;
      logic       stall;
      logic       busy;
   } exp_t;

   exp_t       sbq[$];
   int         errors = 0;
   int         checks = 0;
   int         model_rem = 0;
   logic       obs_busy, obs_stall, obs_fa_d;
   logic [1:0] obs_fa_e;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic hit(input logic [4:0] src, input logic [4:0] dst);
      return (src != 5'd0) && (src == dst);
   endfunction

   function automatic logic [1:0] fwd_e(input logic [4:0] src);
      if (reg_write_M && hit(src, write_reg_M)) return 2'b10;
      if (reg_write_W && hit(src, write_reg_W)) return 2'b01;
      return 2'b00;
   endfunction

   task automatic idle_inputs();
      rs_D = 0; rt_D = 0; rs_E = 0; rt_E = 0;
      write_reg_E = 0; write_reg_M = 0; write_reg_W = 0;
      reg_write_E = 0; reg_write_M = 0; reg_write_W = 0;
      mem_to_reg_E = 0; mem_to_reg_M = 0;
      branch_D = 0; md_op_D = 0; mfhilo_D = 0; md_start_E = 0; md_is_div_E = 0;
   endtask

   // Push the expectation for the inputs now applied, compare at negedge, then advance the model
   task automatic cycle();
      exp_t e, got;
      logic lw, br, md;
      e = '0;
      e.busy = (model_rem > 0);
      if (!reset) begin
         e.fa_d = reg_write_M && hit(rs_D, write_reg_M) && !mem_to_reg_M;
         e.fb_d = reg_write_M && hit(rt_D, write_reg_M) && !mem_to_reg_M;
         e.fa_e = fwd_e(rs_E);
         e.fb_e = fwd_e(rt_E);
         lw = mem_to_reg_E && (hit(rs_D, write_reg_E) || hit(rt_D, write_reg_E));
         br = branch_D && ((reg_write_E && (hit(rs_D, write_reg_E) || hit(rt_D, write_reg_E))) ||
                           (mem_to_reg_M && (hit(rs_D, write_reg_M) || hit(rt_D, write_reg_M))));
         md = (mfhilo_D || md_op_D) && (e.busy || md_start_E);
         e.stall = lw || br || md;
      end
      sbq.push_back(e);
      @(negedge clk);
      got = sbq.pop_front();
      chk("forward_a_D", forward_a_D, got.fa_d);
      chk("forward_b_D", forward_b_D, got.fb_d);
      chk("forward_a_E", forward_a_E, got.fa_e);
      chk("forward_b_E", forward_b_E, got.fb_e);
      chk("stall_F", stall_F, got.stall);
      chk("stall_D", stall_D, got.stall);
      chk("flush_E", flush_E, got.stall);
      chk("md_busy", md_busy, got.busy);
      obs_busy  = md_busy;
      obs_stall = stall_F;
      obs_fa_d  = forward_a_D;
      obs_fa_e  = forward_a_E;
      @(posedge clk);
      if (reset)              model_rem = 0;
      else if (model_rem > 0) model_rem = model_rem - 1;
      else if (md_start_E)    model_rem = md_is_div_E ? 32 : 4;
      #1;
   endtask

   // Issue mult/div, then hold an mfhi in D until it is released; optionally re-issue mid-busy
   task automatic run_md(input logic div, input int exp_n, input logic reissue);
      int n_busy, n_stall;
      n_busy = 0;
      n_stall = 0;
      md_start_E = 1; md_is_div_E = div; mfhilo_D = 0;
      cycle();
      md_start_E = 0; mfhilo_D = 1;
      for (int i = 0; i < 100; i++) begin
         md_start_E = reissue && (i == 1);
         cycle();
         md_start_E = 0;
         if (obs_busy)  n_busy++;
         if (obs_stall) n_stall++;
         if (!obs_stall) break;
      end
      chk(div ? "div_busy_len" : "mult_busy_len", n_busy, exp_n);
      chk(div ? "div_stall_len" : "mult_stall_len", n_stall, exp_n);
      chk("mfhi_release_busy", obs_busy, 0);
      mfhilo_D = 0;
   endtask

   initial begin
      idle_inputs();
      reset = 1;
      reg_write_M = 1; write_reg_M = 3; rs_D = 3; rs_E = 3;
      mem_to_reg_E = 1; write_reg_E = 3;
      @(posedge clk); #1;
      cycle();
      chk("reset_fwd_a_E", obs_fa_e, 2'b00);
      cycle();
      reset = 0;
      idle_inputs();
      cycle();

      // lw $2 in E, add using $2 in D
      mem_to_reg_E = 1; reg_write_E = 1; write_reg_E = 2; rs_D = 2; rt_D = 4;
      cycle();
      chk("lw_stall", obs_stall, 1);
      idle_inputs();
      reg_write_M = 1; mem_to_reg_M = 1; write_reg_M = 2; rs_D = 2; rt_D = 4;
      cycle();
      chk("lw_stall_once", obs_stall, 0);
      idle_inputs();
      reg_write_W = 1; write_reg_W = 2; rs_E = 2; rt_E = 4;
      cycle();
      chk("lw_fwd_w", obs_fa_e, 2'b01);

      // beq $5,$6 with producer of $5 in M, then in E
      idle_inputs();
      branch_D = 1; rs_D = 5; rt_D = 6; reg_write_M = 1; write_reg_M = 5;
      cycle();
      chk("br_fwd_m", obs_fa_d, 1);
      chk("br_no_stall", obs_stall, 0);
      idle_inputs();
      branch_D = 1; rs_D = 5; rt_D = 6; reg_write_E = 1; write_reg_E = 5;
      cycle();
      chk("br_stall_e", obs_stall, 1);
      idle_inputs();
      branch_D = 1; rs_D = 5; rt_D = 6; reg_write_M = 1; write_reg_M = 5;
      cycle();
      chk("br_fwd_after", obs_fa_d, 1);

      // $0 never forwards
      idle_inputs();
      reg_write_M = 1; write_reg_M = 0; rs_D = 0; rs_E = 0;
      cycle();
      chk("zero_fwd_D", obs_fa_d, 0);
      chk("zero_fwd_E", obs_fa_e, 2'b00);

      // M has priority over W
      idle_inputs();
      reg_write_M = 1; write_reg_M = 7; reg_write_W = 1; write_reg_W = 7; rs_E = 7; rt_E = 7;
      cycle();
      chk("m_priority", obs_fa_e, 2'b10);

      idle_inputs();
      run_md(1'b1, 32, 1'b0);
      run_md(1'b0, 4, 1'b0);
      run_md(1'b0, 4, 1'b1);

      // reset at cycle 10 of a div aborts it
      idle_inputs();
      md_start_E = 1; md_is_div_E = 1;
      cycle();
      md_start_E = 0; md_op_D = 1;
      repeat (9) cycle();
      chk("div_mid_busy", obs_busy, 1);
      reset = 1;
      cycle();
      reset = 0;
      cycle();
      chk("abort_busy", obs_busy, 0);
      chk("abort_stall", obs_stall, 0);
      idle_inputs();
      run_md(1'b0, 4, 1'b0);

      // Random traffic with a narrow register range to force collisions
      for (int i = 0; i < 300; i++) begin
         rs_D = 5'($urandom_range(0, 3)); rt_D = 5'($urandom_range(0, 3));
         rs_E = 5'($urandom_range(0, 3)); rt_E = 5'($urandom_range(0, 3));
         write_reg_E = 5'($urandom_range(0, 3));
         write_reg_M = 5'($urandom_range(0, 3));
         write_reg_W = 5'($urandom_range(0, 3));
         reg_write_E = 1'($urandom); reg_write_M = 1'($urandom); reg_write_W = 1'($urandom);
         mem_to_reg_E = 1'($urandom); mem_to_reg_M = 1'($urandom);
         branch_D = 1'($urandom); md_op_D = ($urandom_range(0, 3) == 0);
         mfhilo_D = ($urandom_range(0, 3) == 0);
         md_start_E = ($urandom_range(0, 7) == 0); md_is_div_E = 1'($urandom);
         reset = ($urandom_range(0, 63) == 0);
         cycle();
      end
      reset = 0;
      idle_inputs();
      cycle();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
